// File: rtl/apb_pkg.sv
// Shared APB definitions: requester FSM states and default bus widths.
package apb_pkg;

  localparam int APB_ADDR_W = 8;
  localparam int APB_DATA_W = 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } apb_state_e;

endpackage

// File: rtl/apb_master.sv
// APB requester: turns a valid/ready command into one SETUP/ACCESS transfer and a one-cycle response.
// Optional ACCESS timeout abort is compiled in when APB_MASTER_TIMEOUT_EN is defined.
module apb_master
  import apb_pkg::*;
#(
  parameter int ADDR_W  = APB_ADDR_W,
  parameter int DATA_W  = APB_DATA_W,
  parameter int TIMEOUT = 16
) (
  input  logic              PCLK,
  input  logic              PRESET,
  input  logic              CMD_VALID,
  input  logic              CMD_WRITE,
  input  logic [ADDR_W-1:0] CMD_ADDR,
  input  logic [DATA_W-1:0] CMD_WDATA,
  output logic              CMD_READY,
  output logic              RSP_VALID,
  output logic [DATA_W-1:0] RSP_RDATA,
  output logic              RSP_ERR,
  output logic              PSELx,
  output logic              PENABLE,
  output logic              PWRITE,
  output logic [ADDR_W-1:0] PADDR,
  output logic [DATA_W-1:0] PWDATA,
  input  logic              PREADY,
  input  logic [DATA_W-1:0] PRDATA,
  output logic              BUSY
);

  apb_state_e state, state_nxt;
  logic       accept, done, expire;

`ifdef APB_MASTER_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT) + 1;
  logic [CNT_W-1:0] wait_cnt;

  // PREADY in the final allowed cycle still completes normally.
  assign expire = (state == ACCESS) && !PREADY && (wait_cnt == CNT_W'(TIMEOUT - 1));

  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      wait_cnt <= '0;
      RSP_ERR  <= 1'b0;
    end else begin
      RSP_ERR <= expire;
      if (accept)
        wait_cnt <= '0;
      else if (state == ACCESS && !PREADY)
        wait_cnt <= wait_cnt + 1'b1;
    end
  end
`else
  assign expire  = 1'b0;
  assign RSP_ERR = 1'b0;
`endif

  always_comb begin
    state_nxt = state;
    CMD_READY = 1'b0;
    case (state)
      IDLE: begin
        CMD_READY = 1'b1;
        if (CMD_VALID) state_nxt = SETUP;
      end
      SETUP: state_nxt = ACCESS;
      ACCESS: begin
        if (PREADY) begin
          // Completion edge can take the next command with no IDLE bubble.
          CMD_READY = 1'b1;
          state_nxt = CMD_VALID ? SETUP : IDLE;
        end else if (expire) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign accept  = CMD_VALID && CMD_READY;
  assign done    = (state == ACCESS) && PREADY;
  assign PSELx   = (state != IDLE);
  assign PENABLE = (state == ACCESS);
  assign BUSY    = (state != IDLE);

  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      state     <= IDLE;
      PWRITE    <= 1'b0;
      PADDR     <= '0;
      PWDATA    <= '0;
      RSP_VALID <= 1'b0;
      RSP_RDATA <= '0;
    end else begin
      state     <= state_nxt;
      RSP_VALID <= done || expire;
      RSP_RDATA <= (done && !PWRITE) ? PRDATA : '0;
      if (accept) begin
        PWRITE <= CMD_WRITE;
        PADDR  <= CMD_ADDR;
        PWDATA <= CMD_WDATA;
      end
    end
  end

endmodule

// File: tb/tb_apb_master.sv
// Directed bench for apb_master: per-cycle vector table plus reset/wait/timeout sequences.
module tb_apb_master;
  import apb_pkg::*;

  logic       PCLK = 1'b0;
  logic       PRESET;
  logic       CMD_VALID, CMD_WRITE;
  logic [7:0] CMD_ADDR, CMD_WDATA;
  logic       CMD_READY;
  logic       RSP_VALID, RSP_ERR;
  logic [7:0] RSP_RDATA;
  logic       PSELx, PENABLE, PWRITE;
  logic [7:0] PADDR, PWDATA;
  logic       PREADY;
  logic [7:0] PRDATA;
  logic       BUSY;

  int checks = 0;
  int errors = 0;

  apb_master #(.ADDR_W(8), .DATA_W(8), .TIMEOUT(16)) dut (
    .PCLK(PCLK), .PRESET(PRESET),
    .CMD_VALID(CMD_VALID), .CMD_WRITE(CMD_WRITE), .CMD_ADDR(CMD_ADDR), .CMD_WDATA(CMD_WDATA),
    .CMD_READY(CMD_READY),
    .RSP_VALID(RSP_VALID), .RSP_RDATA(RSP_RDATA), .RSP_ERR(RSP_ERR),
    .PSELx(PSELx), .PENABLE(PENABLE), .PWRITE(PWRITE), .PADDR(PADDR), .PWDATA(PWDATA),
    .PREADY(PREADY), .PRDATA(PRDATA), .BUSY(BUSY)
  );

  always #5 PCLK = ~PCLK;

  typedef struct {
    logic       cv, cw;
    logic [7:0] ca, cd;
    logic       pr;
    logic [7:0] prd;
    logic       psel, pen, pw;
    logic [7:0] pa, pwd;
    logic       crdy, rv;
    logic [7:0] rd;
    logic       busy;
  } vec_t;

  vec_t vec [18];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Step to 1 time unit after the next rising edge.
  task automatic step();
    @(posedge PCLK);
    #1;
  endtask

  task automatic drive(input logic cv, input logic cw, input logic [7:0] ca, input logic [7:0] cd,
                       input logic pr, input logic [7:0] prd);
    CMD_VALID = cv; CMD_WRITE = cw; CMD_ADDR = ca; CMD_WDATA = cd;
    PREADY = pr; PRDATA = prd;
  endtask

  function automatic logic [31:0] outs();
    return {7'd0, PSELx, PENABLE, PWRITE, PADDR, PWDATA, CMD_READY, RSP_VALID, RSP_RDATA, RSP_ERR, BUSY};
  endfunction

  function automatic logic [31:0] exp_of(input vec_t v);
    return {7'd0, v.psel, v.pen, v.pw, v.pa, v.pwd, v.crdy, v.rv, v.rd, 1'b0, v.busy};
  endfunction

  initial begin
    int n;
    int cnt;
    logic bad;

    //          cv cw ca     cd     pr prd    psel pen pw pa     pwd    crdy rv rd     busy
    vec[0]  = '{0, 0, 8'h00, 8'h00, 0, 8'h00, 0, 0, 0, 8'h00, 8'h00, 1, 0, 8'h00, 0};
    vec[1]  = '{1, 1, 8'h00, 8'hA5, 0, 8'h00, 0, 0, 0, 8'h00, 8'h00, 1, 0, 8'h00, 0};
    vec[2]  = '{0, 0, 8'h00, 8'h00, 0, 8'h00, 1, 0, 1, 8'h00, 8'hA5, 0, 0, 8'h00, 1};
    vec[3]  = '{0, 0, 8'h00, 8'h00, 1, 8'h77, 1, 1, 1, 8'h00, 8'hA5, 1, 0, 8'h00, 1};
    vec[4]  = '{0, 0, 8'h00, 8'h00, 0, 8'h00, 0, 0, 1, 8'h00, 8'hA5, 1, 1, 8'h00, 0};
    vec[5]  = '{1, 0, 8'h04, 8'hEE, 0, 8'h00, 0, 0, 1, 8'h00, 8'hA5, 1, 0, 8'h00, 0};
    vec[6]  = '{1, 1, 8'h99, 8'h99, 0, 8'h00, 1, 0, 0, 8'h04, 8'hEE, 0, 0, 8'h00, 1};
    vec[7]  = '{1, 1, 8'h99, 8'h99, 0, 8'h00, 1, 1, 0, 8'h04, 8'hEE, 0, 0, 8'h00, 1};
    vec[8]  = '{0, 0, 8'h00, 8'h00, 0, 8'h00, 1, 1, 0, 8'h04, 8'hEE, 0, 0, 8'h00, 1};
    vec[9]  = '{0, 0, 8'h00, 8'h00, 1, 8'h3C, 1, 1, 0, 8'h04, 8'hEE, 1, 0, 8'h00, 1};
    vec[10] = '{0, 0, 8'h00, 8'h00, 0, 8'h00, 0, 0, 0, 8'h04, 8'hEE, 1, 1, 8'h3C, 0};
    vec[11] = '{1, 1, 8'h00, 8'h11, 0, 8'h00, 0, 0, 0, 8'h04, 8'hEE, 1, 0, 8'h00, 0};
    vec[12] = '{1, 0, 8'h04, 8'h22, 0, 8'h00, 1, 0, 1, 8'h00, 8'h11, 0, 0, 8'h00, 1};
    vec[13] = '{1, 0, 8'h04, 8'h22, 1, 8'hC3, 1, 1, 1, 8'h00, 8'h11, 1, 0, 8'h00, 1};
    vec[14] = '{0, 0, 8'h00, 8'h00, 0, 8'h00, 1, 0, 0, 8'h04, 8'h22, 0, 1, 8'h00, 1};
    vec[15] = '{0, 0, 8'h00, 8'h00, 1, 8'h5A, 1, 1, 0, 8'h04, 8'h22, 1, 0, 8'h00, 1};
    vec[16] = '{0, 0, 8'h00, 8'h00, 0, 8'h00, 0, 0, 0, 8'h04, 8'h22, 1, 1, 8'h5A, 0};
    vec[17] = '{0, 0, 8'h00, 8'h00, 0, 8'h00, 0, 0, 0, 8'h04, 8'h22, 1, 0, 8'h00, 0};

    PRESET = 1'b1;
    drive(0, 0, 8'h00, 8'h00, 0, 8'h00);
    repeat (2) step();
    @(negedge PCLK);
    chk("reset_state", outs(), {7'd0, 3'b000, 8'h00, 8'h00, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0});
    step();
    PRESET = 1'b0;

    // Zero-wait write, two-wait read, then back-to-back write/read.
    foreach (vec[i]) begin
      drive(vec[i].cv, vec[i].cw, vec[i].ca, vec[i].cd, vec[i].pr, vec[i].prd);
      @(negedge PCLK);
      chk($sformatf("row%0d", i), outs(), exp_of(vec[i]));
      step();
    end

    // Reset during a wait state aborts silently.
    drive(1, 0, 8'h08, 8'h00, 0, 8'h00);
    step();
    drive(0, 0, 8'h00, 8'h00, 0, 8'h00);
    step();
    @(negedge PCLK);
    chk("rst_pre_access", {31'd0, PENABLE}, 32'd1);
    PRESET = 1'b1;
    step();
    PRESET = 1'b0;
    PREADY = 1'b1;
    @(negedge PCLK);
    chk("rst_abort", {29'd0, PSELx, PENABLE, BUSY, RSP_VALID, PADDR}, 32'd0);
    bad = 1'b0;
    repeat (3) begin
      step();
      @(negedge PCLK);
      if (RSP_VALID || BUSY) bad = 1'b1;
    end
    chk("rst_no_rsp", {31'd0, bad}, 32'd0);

    drive(1, 1, 8'h10, 8'h55, 1, 8'h00);
    step();
    drive(0, 0, 8'h00, 8'h00, 1, 8'h00);
    step();
    step();
    @(negedge PCLK);
    chk("post_rst_rsp", {22'd0, RSP_VALID, RSP_ERR, RSP_RDATA}, {22'd0, 1'b1, 1'b0, 8'h00});
    step();

`ifdef APB_MASTER_TIMEOUT_EN
    // Held-off PREADY aborts after TIMEOUT ACCESS cycles.
    drive(1, 0, 8'h04, 8'h00, 0, 8'h00);
    step();
    drive(0, 0, 8'h00, 8'h00, 0, 8'h00);
    cnt = 0;
    bad = 1'b0;
    for (n = 0; n < 40; n++) begin
      @(negedge PCLK);
      if (RSP_VALID) break;
      if (PENABLE) begin
        cnt++;
        if (CMD_READY) bad = 1'b1;
      end
      step();
    end
    chk("to_rsp_seen", {31'd0, RSP_VALID}, 32'd1);
    chk("to_access_cycles", cnt, 32'd16);
    chk("to_err", {22'd0, RSP_ERR, BUSY, RSP_RDATA}, {22'd0, 1'b1, 1'b0, 8'h00});
    chk("to_no_ready", {31'd0, bad}, 32'd0);
    step();

    // PREADY in the last allowed cycle completes normally.
    drive(1, 0, 8'h04, 8'h00, 0, 8'h00);
    step();
    drive(0, 0, 8'h00, 8'h00, 0, 8'h00);
    step();
    repeat (15) step();
    PREADY = 1'b1; PRDATA = 8'h6B;
    @(negedge PCLK);
    chk("to_edge_access", {31'd0, PENABLE}, 32'd1);
    step();
    PREADY = 1'b0;
    @(negedge PCLK);
    chk("to_edge_rsp", {22'd0, RSP_VALID, RSP_ERR, RSP_RDATA}, {22'd0, 1'b1, 1'b0, 8'h6B});
    step();
`else
    // Without the timeout build ACCESS waits indefinitely.
    drive(1, 0, 8'h04, 8'h00, 0, 8'h00);
    step();
    drive(0, 0, 8'h00, 8'h00, 0, 8'h00);
    step();
    bad = 1'b0;
    cnt = 0;
    repeat (100) begin
      @(negedge PCLK);
      if (RSP_ERR || RSP_VALID) bad = 1'b1;
      if (PENABLE) cnt++;
      step();
    end
    chk("nto_no_err", {31'd0, bad}, 32'd0);
    chk("nto_access_cycles", cnt, 32'd100);
    PREADY = 1'b1; PRDATA = 8'h81;
    step();
    PREADY = 1'b0;
    @(negedge PCLK);
    chk("nto_release_rsp", {22'd0, RSP_VALID, RSP_ERR, RSP_RDATA}, {22'd0, 1'b1, 1'b0, 8'h81});
    step();
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
